// File: rtl/recip_pkg.sv
// Shared definitions for the reciprocal-engine arbiter.
//   state_t   : controller FSM encoding (2 bits)
//   Q511_ONE  : 1.0 in Q5.11 fixed point
package recip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [15:0] Q511_ONE = 16'h0800;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
//   clk, arst : clock, asynchronous active-high reset
//   req       : per-requester request vector
//   advance   : commit the current grant; the pointer moves to the winner
//   grant     : one-hot winner (combinational, zero when no request)
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] win_idx;
  logic          found;

  // Pointer resets to the top index so the first search starts at requester 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      last_q <= IW'(NUM_REQ - 1);
    else if (advance && found)
      last_q <= win_idx;
  end

  always_comb begin
    grant   = '0;
    win_idx = last_q;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_q) + i) % NUM_REQ]) begin
        found   = 1'b1;
        grant[(int'(last_q) + i) % NUM_REQ] = 1'b1;
        win_idx = IW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/recip_arbiter.sv
// Shares one reciprocal engine between NUM_REQ requesters.
//   clk, arst                  : clock, asynchronous active-high reset
//   i_req_valid/_data/_num     : packed per-requester requests
//   o_req_ready                : one-hot accept strobe
//   o_eng_enable/_in/_num      : engine drive; i_eng_out/_valid engine result
//   o_rsp_valid/_id/_data/_err : response held until i_rsp_ready
//   o_busy                     : controller not in IDLE
//
// state      | meaning
// IDLE       | waiting for a request; grants the round-robin winner
// RUN        | engine enabled with latched operand; waits for valid or timeout
// RESP       | response presented, held until consumer accepts
// RELEASE    | one cycle with engine disabled so it clears its counters
module recip_arbiter
  import recip_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 16,
  parameter int CNT_BIT = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*CNT_BIT-1:0]   i_req_num,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_eng_enable,
  output logic [DWIDTH-1:0]            o_eng_in,
  output logic [CNT_BIT-1:0]           o_eng_num,
  input  logic [DWIDTH-1:0]            i_eng_out,
  input  logic                         i_eng_valid,
  output logic                         o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   o_rsp_id,
  output logic [DWIDTH-1:0]            o_rsp_data,
  output logic                         o_rsp_err,
  input  logic                         i_rsp_ready,
  output logic                         o_busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [DWIDTH-1:0]  sel_data;
  logic [CNT_BIT-1:0] sel_num;
  logic [IDW-1:0]     sel_id;
  logic [TW-1:0]      run_cnt;
  logic               timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .arst    (arst),
    .req     (i_req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept      = (state_q == ST_IDLE) && (|i_req_valid);
  // Gated by arst so no accept strobe escapes while reset is held.
  assign o_req_ready = (accept && !arst) ? grant : '0;
  assign timeout_hit = (run_cnt == TW'(TIMEOUT - 1));

  assign o_eng_enable = (state_q == ST_RUN);
  assign o_rsp_valid  = (state_q == ST_RESP);
  assign o_busy       = (state_q != ST_IDLE);

  always_comb begin
    sel_data = '0;
    sel_num  = '0;
    sel_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_data = i_req_data[k*DWIDTH +: DWIDTH];
        sel_num  = i_req_num[k*CNT_BIT +: CNT_BIT];
        sel_id   = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_RUN;
      ST_RUN:     if (i_eng_valid || timeout_hit) state_d = ST_RESP;
      ST_RESP:    if (i_rsp_ready) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_eng_in   <= '0;
      o_eng_num  <= '0;
      o_rsp_id   <= '0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      run_cnt    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            o_eng_in  <= sel_data;
            o_eng_num <= sel_num;
            o_rsp_id  <= sel_id;
            run_cnt   <= '0;
          end
        end
        ST_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // A real result wins over a timeout landing on the same cycle.
          if (i_eng_valid) begin
            o_rsp_data <= i_eng_out;
            o_rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_arbiter.sv
module tb_recip_arbiter;
  import recip_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              arst;
  logic [NR-1:0]     i_req_valid;
  logic [NR*DW-1:0]  i_req_data;
  logic [NR*CW-1:0]  i_req_num;
  logic [NR-1:0]     o_req_ready;
  logic              o_eng_enable;
  logic [DW-1:0]     o_eng_in;
  logic [CW-1:0]     o_eng_num;
  logic [DW-1:0]     i_eng_out;
  logic              i_eng_valid;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [DW-1:0]     o_rsp_data;
  logic              o_rsp_err;
  logic              i_rsp_ready;
  logic              o_busy;

  recip_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .CNT_BIT(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_num(i_req_num),
    .o_req_ready(o_req_ready),
    .o_eng_enable(o_eng_enable), .o_eng_in(o_eng_in), .o_eng_num(o_eng_num),
    .i_eng_out(i_eng_out), .i_eng_valid(i_eng_valid),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
    logic [15:0] num;
    int          exp_id;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   rel_cnt = 0;

  // Behavioural engine: result = 2^22 / x (Q5.11 reciprocal), after stub_lat enabled cycles.
  int stub_cnt = 0;
  bit stub_mute = 1'b0;
  int stub_lat = 3;

  function automatic logic [15:0] recip(input logic [15:0] x);
    int unsigned q;
    if (x == 16'h0) return 16'hFFFF;
    q = 32'h0040_0000 / {16'h0, x};
    return (q > 32'h0000_FFFF) ? 16'hFFFF : q[15:0];
  endfunction

  always @(posedge clk) begin
    if (!o_eng_enable) begin
      stub_cnt    <= 0;
      i_eng_valid <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!stub_mute && stub_cnt == stub_lat - 1) begin
        i_eng_valid <= 1'b1;
        i_eng_out   <= recip(o_eng_in);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [15:0] act, input logic [15:0] exp);
    int d;
    d = int'(act) - int'(exp);
    n_vec++;
    if (d < -2 || d > 2) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h +-2", name, act, exp);
    end
  endtask

  // Response scoreboard plus RELEASE / RESP invariants.
  always @(negedge clk) begin
    rsp_t e;
    if (arst) begin
      rel_cnt = 0;
    end else begin
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL rsp_unexpected: got id %0d data %h, want no response", o_rsp_id, o_rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(o_rsp_id), e.id);
          check("rsp_err", 32'(o_rsp_err), 32'(e.err));
          check_tol("rsp_data", o_rsp_data, e.data);
        end
      end
      if (o_rsp_valid) check("resp_eng_off", 32'(o_eng_enable), 0);
      if (o_busy && !o_eng_enable && !o_rsp_valid) begin
        rel_cnt++;
        check("release_ready", 32'(o_req_ready), 0);
      end else if (rel_cnt > 0) begin
        check("release_len", rel_cnt, 1);
        check("release_to_idle", 32'(o_busy), 0);
        rel_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] mask, input logic [15:0] data, input logic [15:0] num,
                       input int exp_id, input logic [15:0] exp_data, input logic exp_err,
                       input bit push);
    int t;
    @(posedge clk); #1;
    i_req_valid = mask;
    for (int k = 0; k < NR; k++) begin
      i_req_data[k*DW +: DW] = data;
      i_req_num[k*CW +: CW]  = num;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_req_ready == '0 && t < 300);
    if (o_req_ready == '0) begin
      n_vec++; n_miss++;
      $display("FAIL grant_timeout: got no grant, want id %0d", exp_id);
      i_req_valid = '0;
      return;
    end
    check("grant", 32'(o_req_ready), 32'(1) << exp_id);
    if (push) sb.push_back('{exp_id, exp_data, exp_err});
    @(posedge clk); #1;
    i_req_valid = '0;
    check("accept_to_enable", 32'(o_eng_enable), 1);
    check("eng_in", 32'(o_eng_in), 32'(data));
    check("eng_num", 32'(o_eng_num), 32'(num));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || o_busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_vec++; n_miss++;
      $display("FAIL idle_timeout: got busy with %0d pending, want idle", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready), 0);
    check({tag, "_eng_enable"}, 32'(o_eng_enable), 0);
    check({tag, "_eng_in"}, 32'(o_eng_in), 0);
    check({tag, "_eng_num"}, 32'(o_eng_num), 0);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(o_rsp_id), 0);
    check({tag, "_rsp_data"}, 32'(o_rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(o_rsp_err), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int k;
    // Expected ids follow the round-robin pointer carried across the table.
    vecs[0] = '{4'b0001, Q511_ONE, 16'd1, 0, 16'h0800, 1'b0};
    vecs[1] = '{4'b1111, 16'h1000, 16'd2, 1, 16'h0400, 1'b0};
    vecs[2] = '{4'b1111, 16'h0400, 16'd3, 2, 16'h1000, 1'b0};
    vecs[3] = '{4'b1111, 16'h2000, 16'd4, 3, 16'h0200, 1'b0};
    vecs[4] = '{4'b1111, 16'h0800, 16'd5, 0, 16'h0800, 1'b0};
    vecs[5] = '{4'b0100, 16'h0C00, 16'd6, 2, 16'h0555, 1'b0};
    vecs[6] = '{4'b1010, 16'h0200, 16'd7, 3, 16'h2000, 1'b0};
    vecs[7] = '{4'b0011, 16'h4000, 16'd8, 0, 16'h0100, 1'b0};
    vecs[8] = '{4'b0010, 16'h0100, 16'd9, 1, 16'h4000, 1'b0};

    arst        = 1'b1;
    i_req_valid = 4'b1111;
    i_req_data  = '1;
    i_req_num   = '1;
    i_rsp_ready = 1'b1;
    i_eng_out   = '0;
    i_eng_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    arst        = 1'b0;
    i_req_valid = '0;

    for (int i = 0; i < 9; i++)
      issue(vecs[i].mask, vecs[i].data, vecs[i].num, vecs[i].exp_id,
            vecs[i].exp_data, vecs[i].exp_err, 1'b1);
    wait_idle();

    // Consumer stall: response must hold for 10 cycles with engine off.
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    issue(4'b0001, 16'h1000, 16'd1, 0, 16'h0400, 1'b0, 1'b1);
    k = 0;
    while (!o_rsp_valid && k < 50) begin @(negedge clk); k++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(o_rsp_valid), 1);
      check_tol("stall_data", o_rsp_data, 16'h0400);
      check("stall_id", 32'(o_rsp_id), 0);
      check("stall_eng_off", 32'(o_eng_enable), 0);
    end
    @(posedge clk); #1;
    i_rsp_ready = 1'b1;
    wait_idle();

    // Timeout: response exactly TIMEOUT cycles after RUN entry.
    stub_mute = 1'b1;
    issue(4'b0010, 16'h0800, 16'd4, 1, 16'h0000, 1'b1, 1'b1);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (o_rsp_valid) break;
      k++;
    end
    check("timeout_cycles", k, TO);
    wait_idle();
    stub_mute = 1'b0;

    // Reset in RUN cycle 5 aborts without a response.
    stub_mute = 1'b1;
    issue(4'b0001, 16'h0800, 16'd1, 0, 16'h0800, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    i_req_valid = 4'b0101;
    arst = 1'b1;
    #1;
    check_reset_outputs("midrun");
    @(posedge clk); #1;
    check_reset_outputs("midrun_hold");
    @(negedge clk);
    arst        = 1'b0;
    i_req_valid = '0;
    stub_mute   = 1'b0;
    issue(4'b0100, 16'h1000, 16'd1, 2, 16'h0400, 1'b0, 1'b1);
    wait_idle();

    // Post-reset priority restarts at requester 0.
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    issue(4'b0101, 16'h0200, 16'd1, 0, 16'h2000, 1'b0, 1'b1);
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
